// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants for the 4-digit 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef logic [1:0] digit_t;
    typedef logic [3:0] nibble_t;

    // Active-low {a,b,c,d,e,f,g}; leftmost entry is hex F, rightmost is hex 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b1110010,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] hex_to_seg(input nibble_t nib);
        return SEG_TABLE[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Slot prescaler for scanned displays; counts CLK_DIV cycles per
//               slot and SLOTS slots per frame, flagging the last cycle of each.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int CLK_DIV = 50000,
    parameter int SLOTS   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [$clog2(CLK_DIV)-1:0] cnt,
    output logic                       slot_last,
    output logic                       frame_last
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [CNT_W-1:0]  c_cnt_last   = CNT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] c_slot_first = SLOT_W'(SLOTS - 1);

    logic [SLOT_W-1:0] r_slot;

    assign slot_last  = (cnt == c_cnt_last);
    assign frame_last = slot_last && (r_slot == '0);

    // Slots count downward so slot 0 closes the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            r_slot <= c_slot_first;
        end else if (slot_last) begin
            cnt    <= '0;
            r_slot <= (r_slot == '0) ? c_slot_first : r_slot - 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : 4-digit common-anode 7-segment scanner with frame-aligned
//               load/ack commit. Optional macro: LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        ack,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int               CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] w_cnt;
    logic             w_slot_last;
    logic             w_frame_last;

    digit_t           r_dig;
    logic [15:0]      r_disp;
    logic [15:0]      r_pend;
    logic             r_pend_valid;

    logic             w_commit;
    logic [15:0]      w_disp_nxt;
    nibble_t          w_nib;
    logic             w_lz_blank;
    logic             w_show;
    logic [3:0]       w_an;
    logic [6:0]       w_seg;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV),
        .SLOTS   (NUM_DIGITS)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt        (w_cnt),
        .slot_last  (w_slot_last),
        .frame_last (w_frame_last)
    );

    // Outputs are computed from the post-commit value so the first digit of a
    // new frame already shows the newly committed data.
    always_comb begin
        w_commit   = frame_done && (load || r_pend_valid);
        w_disp_nxt = r_disp;
        if (frame_done) begin
            if (load)
                w_disp_nxt = data_in;
            else if (r_pend_valid)
                w_disp_nxt = r_pend;
        end
        w_nib = w_disp_nxt[{r_dig, 2'b00} +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (r_dig)
            2'd3:    w_lz_blank = (w_disp_nxt[15:12] == 4'h0);
            2'd2:    w_lz_blank = (w_disp_nxt[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (w_disp_nxt[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_show = (w_cnt != c_cnt_last) && !w_lz_blank;
        w_an   = w_show ? ~(4'b0001 << r_dig) : AN_OFF;
        w_seg  = w_show ? hex_to_seg(w_nib)   : SEG_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dig        <= 2'd3;
            r_disp       <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pend_valid <= 1'b0;
            an           <= AN_OFF;
            seg          <= SEG_OFF;
            ack          <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (w_slot_last)
                r_dig <= r_dig - 2'd1;
            r_disp <= w_disp_nxt;
            // A load on the commit cycle bypasses pend; an older pend is dropped.
            if (frame_done) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend       <= data_in;
                r_pend_valid <= 1'b1;
            end
            ack        <= w_commit;
            frame_done <= w_frame_last;
            an         <= w_an;
            seg        <= w_seg;
        end
    end

endmodule
`default_nettype wire
